// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch/decode sequencing, branch resolution on datapath
// flags, and Moore control strobes for PC, IR, RAM, register file and ALU.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] decoded_instruction,
  input  logic       zero,
  input  logic       neg,
  input  logic       unsigned_overflow,
  input  logic       signed_overflow,
  output logic       branch,
  output logic       pc_enable,
  output logic       ir_enable,
  output logic       addr_sel,
  output logic       c_sel,
  output logic       write_reg_enable,
  output logic [1:0] operation,
  output logic       ram_write_enable,
  output logic       halted,
  output logic [2:0] dbg_state
);

  localparam logic [4:0] OP_LOAD   = 5'd1;
  localparam logic [4:0] OP_STORE  = 5'd2;
  localparam logic [4:0] OP_MOVE   = 5'd3;
  localparam logic [4:0] OP_ADD    = 5'd4;
  localparam logic [4:0] OP_SUB    = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_OR     = 5'd7;
  localparam logic [4:0] OP_BRANCH = 5'd8;
  localparam logic [4:0] OP_BZERO  = 5'd9;
  localparam logic [4:0] OP_BNZERO = 5'd10;
  localparam logic [4:0] OP_BNEG   = 5'd11;
  localparam logic [4:0] OP_BNNEG  = 5'd12;
  localparam logic [4:0] OP_BOV    = 5'd13;
  localparam logic [4:0] OP_BNOV   = 5'd14;
  localparam logic [4:0] OP_BSOV   = 5'd15;
  localparam logic [4:0] OP_HALT   = 5'd31;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_LOAD_1   = 3'd2,
    S_LOAD_2   = 3'd3,
    S_STORE_1  = 3'd4,
    S_ALU      = 3'd5,
    S_BRANCH_1 = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic       taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Opcode is captured on leaving DECODE so later states never see IR changes.
  always_comb begin
    opcode_d = opcode_q;
    if (state_q == S_DECODE) opcode_d = decoded_instruction;
  end

  always_comb begin
    taken = 1'b0;
    case (decoded_instruction)
      OP_BRANCH: taken = 1'b1;
      OP_BZERO:  taken = zero;
      OP_BNZERO: taken = ~zero;
      OP_BNEG:   taken = neg;
      OP_BNNEG:  taken = ~neg;
      OP_BOV:    taken = unsigned_overflow;
      OP_BNOV:   taken = ~unsigned_overflow;
      OP_BSOV:   taken = signed_overflow;
      default:   taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          OP_LOAD:  state_d = S_LOAD_1;
          OP_STORE: state_d = S_STORE_1;
          OP_MOVE, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALU;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = taken ? S_BRANCH_1 : S_FETCH;
        endcase
      end
      S_LOAD_1:   state_d = S_LOAD_2;
      S_LOAD_2:   state_d = S_FETCH;
      S_STORE_1:  state_d = S_FETCH;
      S_ALU:      state_d = S_FETCH;
      S_BRANCH_1: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    write_reg_enable = 1'b0;
    operation        = 2'b00;
    ram_write_enable = 1'b0;
    halted           = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
      end
      S_LOAD_1: addr_sel = 1'b1;
      S_LOAD_2: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE_1: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        write_reg_enable = 1'b1;
        // MOVE is an OR against the datapath's zero operand.
        case (opcode_q)
          OP_ADD:  operation = 2'b00;
          OP_SUB:  operation = 2'b01;
          OP_AND:  operation = 2'b10;
          default: operation = 2'b11;
        endcase
      end
      S_BRANCH_1: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Hold every strobe low while reset is asserted, whatever the state.
    if (!rst_n) begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      write_reg_enable = 1'b0;
      operation        = 2'b00;
      ram_write_enable = 1'b0;
      halted           = 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of per-opcode sequences plus
// hand-written reset, halt and opcode-capture sequences.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] decoded_instruction;
  logic       zero, neg, unsigned_overflow, signed_overflow;
  logic       branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable;
  logic [1:0] operation;
  logic       ram_write_enable, halted;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (decoded_instruction),
    .zero                (zero),
    .neg                 (neg),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .write_reg_enable    (write_reg_enable),
    .operation           (operation),
    .ram_write_enable    (ram_write_enable),
    .halted              (halted),
    .dbg_state           (dbg_state)
  );

  always #5 clk = ~clk;

  // Packed view: {halted, ram_we, operation[1:0], wre, c_sel, addr_sel, ir_en, pc_en, branch}
  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_FETCH = 10'b0000000110;
  localparam logic [9:0] O_LD1   = 10'b0000001000;
  localparam logic [9:0] O_LD2   = 10'b0000111000;
  localparam logic [9:0] O_ST    = 10'b0100001000;
  localparam logic [9:0] O_ADD   = 10'b0000100000;
  localparam logic [9:0] O_SUB   = 10'b0001100000;
  localparam logic [9:0] O_AND   = 10'b0010100000;
  localparam logic [9:0] O_OR    = 10'b0011100000;
  localparam logic [9:0] O_BR    = 10'b0000000011;
  localparam logic [9:0] O_HALT  = 10'b1000000000;

  typedef struct {
    logic [4:0] op;
    logic [3:0] flags;  // {zero, neg, unsigned_overflow, signed_overflow}
    int         lat;
    logic [9:0] mid1;
    logic [9:0] mid2;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] outs();
    return {halted, ram_write_enable, operation, write_reg_enable, c_sel,
            addr_sel, ir_enable, pc_enable, branch};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [9:0] exp);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b state=%0d", nm, idx, outs(), exp, dbg_state);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] fl);
    decoded_instruction = op;
    {zero, neg, unsigned_overflow, signed_overflow} = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 4'b0000);

    vecs.push_back('{5'd0,  4'b0000, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd1,  4'b0000, 4, O_LD1,  O_LD2});
    vecs.push_back('{5'd2,  4'b0000, 3, O_ST,   O_NONE});
    vecs.push_back('{5'd3,  4'b0000, 3, O_OR,   O_NONE});
    vecs.push_back('{5'd4,  4'b1111, 3, O_ADD,  O_NONE});
    vecs.push_back('{5'd5,  4'b0000, 3, O_SUB,  O_NONE});
    vecs.push_back('{5'd6,  4'b0000, 3, O_AND,  O_NONE});
    vecs.push_back('{5'd7,  4'b0000, 3, O_OR,   O_NONE});
    vecs.push_back('{5'd8,  4'b0000, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd9,  4'b1000, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd9,  4'b0111, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd10, 4'b0111, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd10, 4'b1000, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd11, 4'b0100, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd11, 4'b1011, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd12, 4'b1011, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd12, 4'b0100, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd13, 4'b0010, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd13, 4'b1101, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd14, 4'b1101, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd14, 4'b0010, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd15, 4'b0001, 3, O_BR,   O_NONE});
    vecs.push_back('{5'd15, 4'b1110, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd16, 4'b1111, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd20, 4'b0000, 2, O_NONE, O_NONE});
    vecs.push_back('{5'd30, 4'b1111, 2, O_NONE, O_NONE});

    // Reset: outputs low while rst_n is low, FETCH outputs once released.
    step();
    step();
    check("rst_low", 0, O_NONE);
    rst_n = 1'b1;
    #1;
    check("rst_release", 0, O_FETCH);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].flags);
      step();
      check("decode", i, O_NONE);
      step();
      if (vecs[i].lat == 2) begin
        check("ret_fetch", i, O_FETCH);
      end else begin
        check("mid1", i, vecs[i].mid1);
        if (vecs[i].lat == 4) begin
          step();
          check("mid2", i, vecs[i].mid2);
        end
        step();
        check("ret_fetch", i, O_FETCH);
      end
    end

    // ALU op comes from the opcode captured in DECODE, not the live input.
    drive(5'd5, 4'b0000);
    step();
    check("latch_decode", 0, O_NONE);
    step();
    drive(5'd7, 4'b0000);
    #1;
    check("latch_alu", 0, O_SUB);
    step();
    check("latch_ret", 0, O_FETCH);

    // HALT holds for 20 cycles, then a one-cycle reset returns to FETCH.
    drive(5'd31, 4'b0000);
    step();
    check("halt_decode", 0, O_NONE);
    step();
    check("halt_enter", 0, O_HALT);
    drive(5'd0, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      step();
      check("halt_hold", k, O_HALT);
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_low", 0, O_NONE);
    step();
    check("halt_rst_edge", 0, O_NONE);
    rst_n = 1'b1;
    #1;
    check("halt_rst_fetch", 0, O_FETCH);

    // Reset mid-LOAD: register write must never happen.
    drive(5'd1, 4'b0000);
    step();
    check("ld_rst_decode", 0, O_NONE);
    step();
    check("ld_rst_ld1", 0, O_LD1);
    rst_n = 1'b0;
    #1;
    check("ld_rst_low", 0, O_NONE);
    step();
    check("ld_rst_edge", 0, O_NONE);
    rst_n = 1'b1;
    drive(5'd0, 4'b0000);
    #1;
    check("ld_rst_fetch", 0, O_FETCH);
    step();
    check("ld_rst_decode2", 0, O_NONE);
    step();
    check("ld_rst_ret", 0, O_FETCH);

    // Reset mid-STORE: back to FETCH, no lingering RAM write.
    drive(5'd2, 4'b0000);
    step();
    step();
    check("st_rst_st1", 0, O_ST);
    rst_n = 1'b0;
    step();
    check("st_rst_edge", 0, O_NONE);
    rst_n = 1'b1;
    drive(5'd0, 4'b0000);
    #1;
    check("st_rst_fetch", 0, O_FETCH);
    step();
    check("st_rst_decode", 0, O_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: decoded_instruction  input  5  opcode from datapath instruction register.
REQ-004 SHALL have ports: zero, neg, unsigned_overflow, signed_overflow  input  1 each  datapath flags, registered in datapath, valid in DECODE.
REQ-005 SHALL have ports: branch  output  1  1 = PC loads IR address field, 0 = PC increments (effective only with pc_enable).
REQ-006 SHALL have ports: pc_enable, ir_enable  output  1 each  PC update and IR load strobes.
REQ-007 SHALL have ports: addr_sel  output  1  0 = PC drives addr_ram, 1 = IR address field drives it.
REQ-008 SHALL have ports: c_sel  output  1  0 = ALU result, 1 = RAM data_out to register-file write port.
REQ-009 SHALL have ports: write_reg_enable  output  1  register-file write strobe.
REQ-010 SHALL have ports: operation  output  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-011 SHALL have ports: ram_write_enable  output  1  RAM write strobe; halted  output  1  high in HALT state.

Function
REQ-012 Opcode map SHALL be: 0 NOP, 1 LOAD, 2 STORE, 3 MOVE, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 BRANCH, 9 BZERO, 10 BNZERO, 11 BNEG, 12 BNNEG, 13 BOV (unsigned_overflow), 14 BNOV, 15 BSOV (signed_overflow), 31 HALT; all other codes SHALL execute as NOP.
REQ-013 FSM states SHALL be FETCH, DECODE, LOAD_1, LOAD_2, STORE_1, ALU, BRANCH_1, HALT; outputs SHALL be Moore (function of state and registered opcode only).
REQ-014 All outputs not listed for a state SHALL be 0; operation SHALL be 00 unless listed.
REQ-015 FETCH: addr_sel=0, ir_enable=1, pc_enable=1, branch=0; next DECODE.
REQ-016 DECODE: all strobes 0; next LOAD_1 (LOAD), STORE_1 (STORE), ALU (MOVE/ADD/SUB/AND/OR), BRANCH_1 (taken branch), HALT (31), else FETCH.
REQ-017 Branch taken SHALL be evaluated in DECODE: BRANCH always; BZERO zero=1; BNZERO zero=0; BNEG neg=1; BNNEG neg=0; BOV unsigned_overflow=1; BNOV unsigned_overflow=0; BSOV signed_overflow=1; not-taken goes to FETCH with PC unchanged from FETCH increment.
REQ-018 LOAD_1: addr_sel=1; next LOAD_2. LOAD_2: addr_sel=1, c_sel=1, write_reg_enable=1; next FETCH.
REQ-019 STORE_1: addr_sel=1, ram_write_enable=1; next FETCH.
REQ-020 ALU: c_sel=0, write_reg_enable=1, operation per opcode (MOVE uses 11 OR with datapath zero-operand convention, ADD 00, SUB 01, AND 10, OR 11); next FETCH.
REQ-021 BRANCH_1: branch=1, pc_enable=1; next FETCH.
REQ-022 HALT: halted=1, all strobes 0; SHALL remain until reset.
REQ-023 Latency in cycles from FETCH entry to next FETCH SHALL be: NOP/not-taken 2, ALU/STORE/taken branch 3, LOAD 4.
REQ-024 ir_enable SHALL assert only in FETCH; ram_write_enable and write_reg_enable SHALL never assert in the same cycle.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state FETCH regardless of current state, including mid-LOAD, mid-STORE and HALT.
REQ-026 During and in the cycle following reset, outputs SHALL equal FETCH outputs only after rst_n=1; while rst_n=0 all outputs SHALL be 0 and halted=0.
REQ-027 No output SHALL be X after the first rising edge with rst_n=0.

Verification
REQ-028 Reset then opcode 4 (ADD): FETCH(ir_enable=1,pc_enable=1) -> DECODE(all 0) -> ALU(write_reg_enable=1,operation=00) -> FETCH.
REQ-029 Opcode 1 (LOAD): LOAD_1 addr_sel=1, LOAD_2 addr_sel=1,c_sel=1,write_reg_enable=1; 4 cycles total.
REQ-030 Opcode 9 with zero=1 -> BRANCH_1 branch=1,pc_enable=1; with zero=0 -> DECODE goes directly to FETCH, branch stays 0.
REQ-031 Opcode 2 (STORE): STORE_1 addr_sel=1, ram_write_enable=1, write_reg_enable=0.
REQ-032 Opcode 31 -> HALT, halted=1 held 20 cycles with all strobes 0; rst_n=0 one cycle -> FETCH, halted=0.
REQ-033 Opcode 20 (undefined) -> treated as NOP, 2 cycles, no strobes besides FETCH's; rst_n=0 asserted in LOAD_1 -> next state FETCH, write_reg_enable never asserted.
